pdm_demod: RTL and testbench
============================

# pdm_demod

PDM demodulator: converts a 1-bit pulse-density stream back into unsigned NBITS-wide samples using a CIC decimation filter of order ORDER and ratio 2^LOG2_DECIM. It is the receive-side counterpart of the team's first-order PDM modulator. It sits between a PDM source (comparator, loopback from the modulator, or external sensor) and downstream sample consumers. Output scaling matches the modulator, so a stream produced from code D demodulates to approximately D.

## Interface
- NBITS, 11, output sample width; full scale MAX = 2^NBITS-1
- ORDER, 3, CIC order (number of integrator and comb stages), 1..5
- LOG2_DECIM, 6, decimation ratio R = 2^LOG2_DECIM; ORDER*LOG2_DECIM >= NBITS required
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- pdm_in  in  1  PDM bit; 1 = +1, 0 = 0
- pdm_en  in  1  input strobe; pdm_in consumed only on cycles with pdm_en=1
- data_out  out  NBITS  decimated sample, unsigned
- data_valid  out  1  one-cycle pulse, data_out updated
- sat  out  1  qualifies data_valid: sample was clamped to MAX

## Operation
- Internal width W = ORDER*LOG2_DECIM+1; all integrator, comb and delay registers are W bits, modular arithmetic (wrap is intentional and harmless).
- On a cycle with pdm_en=1: integrator 1 += pdm_in; integrator k += integrator k-1 (pre-update value chain, one register per stage); decimation counter increments modulo R.
- Counter reaching R-1 with pdm_en=1 raises capture strobe; last integrator value enters the comb pipeline: comb k out = in - delay_k, delay_k <= in; one registered stage per comb.
- Comb result y ranges 0..2^(W-1). Scaling: s = y >> (W-1-NBITS); if s > MAX then data_out = MAX, sat = 1, else data_out = s, sat = 0.
- Warm-up: a counter suppresses data_valid for the first ORDER decimated outputs after reset (filter transient); data_valid asserted for every output thereafter.
- pdm_en=0: integrators, counter and phase frozen; in-flight comb pipeline still drains.
- Reset (asynchronous, any time): all integrators, delays, counters, pipeline valids cleared; data_out=0, data_valid=0, sat=0 immediately; warm-up restarts.

## Timing
- Edge E0 samples the R-th enabled bit of a frame. The capture register and comb stage 1 update at E1, comb stage k at Ek, the output register at E(ORDER+1). data_valid is high for the single cycle following E(ORDER+1). Latency is ORDER+1 clocks; base latency excludes the configuration option below.
- Output rate is exactly one data_valid per R enabled input bits (after warm-up); consecutive pulses are at least R clocks apart when pdm_en is tied high.
- Pipeline never stalls; no backpressure. The consumer must accept data_out on the data_valid cycle.
- pdm_en may toggle every cycle; gaps do not alter sample values, only timing.

## Configuration
- PDM_DEMOD_SYNC_EN defined: pdm_in and pdm_en pass through a 2-flop synchronizer (reset to 0) before the integrators; latency +2 clocks; for asynchronous external PDM sources.
- Not defined: inputs used directly, latency as in Timing.

## Structure
- Package pdm_pkg: function cic_width(order, log2_decim) returning W; shift constant W-1-NBITS; parameter legality checks (elaboration-time assertion for ORDER*LOG2_DECIM >= NBITS).
- One sub-module pdm_demod_comb: single registered comb stage (W-bit difference, delay register, valid in/out), instantiated ORDER times via generate. Integrators stay in the top level.

## Test plan
- Default params, pdm_en=1, pdm_in constant 1: after warm-up every data_valid shows data_out=2047, sat=1; constant 0 gives 0, sat=0.
- Alternating 1,0 pattern: steady-state data_out=1024, sat=0; data_valid period exactly 64 clocks; first 3 outputs suppressed.
- Loopback from the team PDM modulator driven with constant 512, then 1500: steady data_out within ±1 of 512, then of 1500 after settling.
- pdm_en high only every 3rd cycle, alternating pattern: data_out=1024, data_valid spaced 192 clocks; latency from last enabled bit = 4 clocks.
- rst_n pulsed low mid-frame, while a data_valid is pending in the comb pipeline: outputs 0 asynchronously, pending pulse dropped, next data_valid only after 3 suppressed outputs and 4*64 enabled bits.
- With PDM_DEMOD_SYNC_EN: same vectors, identical values, every data_valid delayed by exactly 2 clocks.

Source files
------------

// File: rtl/pdm_demod_pkg.sv
// pdm_pkg: shared sizing helpers for the PDM demodulator (CIC width, output shift, legality).
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
//
// Contents:
//   cic_width(order, log2_decim)        -> W, width of every integrator/comb/delay register
//   cic_shift(order, log2_decim, nbits) -> right shift that maps the comb result onto NBITS
//   cic_params_ok(nbits, order, log2)   -> legal parameter combination

package pdm_pkg;

  // Comb output spans 0..R^ORDER = 2^(ORDER*LOG2_DECIM), so one extra bit
  // above the gain exponent holds the full-scale value without aliasing.
  function automatic int cic_width(input int order, input int log2_decim);
    return order * log2_decim + 1;
  endfunction

  // Full scale R^ORDER sits at bit W-1; dropping W-1-NBITS bits lands it at 2^NBITS.
  function automatic int cic_shift(input int order, input int log2_decim, input int nbits);
    return cic_width(order, log2_decim) - 1 - nbits;
  endfunction

  // Enough CIC gain to cover the output width, and a bounded filter order.
  function automatic bit cic_params_ok(input int nbits, input int order, input int log2_decim);
    return (order >= 1) && (order <= 5) && (log2_decim >= 1) && (nbits >= 1) &&
           (order * log2_decim >= nbits);
  endfunction

endpackage

// File: rtl/pdm_demod_comb.sv
// pdm_demod_comb: one registered CIC comb stage, y = x - x_previous_sample.
// Latency: 1 clock from x_vld to y_vld.
// Backpressure: none; a valid is accepted on every cycle it is presented.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   x_dat, x_vld   decimated sample in and its strobe
//   y_dat, y_vld   differenced sample out and its strobe (valid follows x_vld by one clock)

module pdm_demod_comb #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x_dat,
  input  logic         x_vld,
  output logic [W-1:0] y_dat,
  output logic         y_vld
);

  logic [W-1:0] dly;

  // Modular subtraction: integrator wrap cancels here as long as W covers the gain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly   <= '0;
      y_dat <= '0;
      y_vld <= 1'b0;
    end else begin
      y_vld <= x_vld;
      if (x_vld) begin
        y_dat <= x_dat - dly;
        dly   <= x_dat;
      end
    end
  end

endmodule

// File: rtl/pdm_demod.sv
// pdm_demod: 1-bit PDM stream -> unsigned NBITS samples via an ORDER-stage CIC decimating by 2^LOG2_DECIM.
// Latency: ORDER+1 clocks from the last enabled bit of a frame to data_valid (+2 with PDM_DEMOD_SYNC_EN).
// Backpressure: none; the pipeline never stalls and the consumer must take data_out on the data_valid cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pdm_in       PDM bit (1 = +1, 0 = 0), consumed only when pdm_en = 1
//   pdm_en       input strobe; low freezes integrators and decimation phase
//   data_out     decimated sample, clamped to 2^NBITS-1
//   data_valid   one-cycle pulse, data_out updated (suppressed for the first ORDER outputs)
//   sat          with data_valid: sample was clamped
// Build option: define PDM_DEMOD_SYNC_EN to pass pdm_in/pdm_en through a 2-flop synchronizer.

module pdm_demod
  import pdm_pkg::*;
#(
  parameter int NBITS      = 11,
  parameter int ORDER      = 3,
  parameter int LOG2_DECIM = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_in,
  input  logic             pdm_en,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  output logic             sat
);

  localparam int W     = cic_width(ORDER, LOG2_DECIM);
  localparam int SHIFT = cic_shift(ORDER, LOG2_DECIM, NBITS);

  localparam logic [W-1:0] MAX_W  = {{(W-NBITS){1'b0}}, {NBITS{1'b1}}};
  localparam logic [2:0]   WARM_N = 3'(ORDER);

  generate
    if (!cic_params_ok(NBITS, ORDER, LOG2_DECIM)) begin : g_bad_params
      $error("pdm_demod: need 1 <= ORDER <= 5 and ORDER*LOG2_DECIM >= NBITS");
    end
  endgenerate

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic bit_in;
  logic bit_en;

`ifdef PDM_DEMOD_SYNC_EN
  // Both strobe and data go through the same depth so they stay aligned.
  logic [1:0] in_sync;
  logic [1:0] en_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sync <= '0;
      en_sync <= '0;
    end else begin
      in_sync <= {in_sync[0], pdm_in};
      en_sync <= {en_sync[0], pdm_en};
    end
  end

  assign bit_in = in_sync[1];
  assign bit_en = en_sync[1];
`else
  assign bit_in = pdm_in;
  assign bit_en = pdm_en;
`endif

  // ------------------------------------------------------------------
  // Integrators and decimation phase
  // ------------------------------------------------------------------
  // Each integrator adds the previous stage's pre-update value, so stage k
  // lags the input by k-1 enabled bits. That is a pure delay and leaves the
  // filter response (and DC gain R^ORDER) unchanged.
  logic [W-1:0]          integ [ORDER];
  logic [LOG2_DECIM-1:0] phase;
  logic                  cap_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
      end
      phase   <= '0;
      cap_vld <= 1'b0;
    end else begin
      // R-th enabled bit of the frame: next clock the last integrator is
      // taken into comb stage 1.
      cap_vld <= bit_en && (phase == {LOG2_DECIM{1'b1}});
      if (bit_en) begin
        integ[0] <= integ[0] + W'(bit_in);
        for (int k = 1; k < ORDER; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        phase <= phase + LOG2_DECIM'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Comb pipeline: one registered stage per order, drains even when pdm_en=0
  // ------------------------------------------------------------------
  logic [ORDER:0][W-1:0] comb_dat;
  logic [ORDER:0]        comb_vld;

  assign comb_dat[0] = integ[ORDER-1];
  assign comb_vld[0] = cap_vld;

  generate
    for (genvar g = 0; g < ORDER; g++) begin : g_comb
      pdm_demod_comb #(
        .W (W)
      ) u_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .x_dat (comb_dat[g]),
        .x_vld (comb_vld[g]),
        .y_dat (comb_dat[g+1]),
        .y_vld (comb_vld[g+1])
      );
    end
  endgenerate

  // ------------------------------------------------------------------
  // Scaling, clamping, warm-up suppression and output register
  // ------------------------------------------------------------------
  // Only an all-ones input reaches y = 2^(W-1), which scales to 2^NBITS and
  // is the one case that clamps.
  logic [W-1:0] y_full;
  logic [W-1:0] y_scaled;
  logic [2:0]   warm;

  assign y_full   = comb_dat[ORDER];
  assign y_scaled = y_full >> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      sat        <= 1'b0;
      warm       <= '0;
    end else begin
      data_valid <= 1'b0;
      if (comb_vld[ORDER]) begin
        // The first ORDER outputs still contain the start-up transient of
        // the integrator/comb state and are dropped.
        if (warm != WARM_N) begin
          warm <= warm + 3'd1;
        end else begin
          data_valid <= 1'b1;
          if (y_scaled > MAX_W) begin
            data_out <= '1;
            sat      <= 1'b1;
          end else begin
            data_out <= y_scaled[NBITS-1:0];
            sat      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: directed vectors for pdm_demod (constants, alternating, sparse enable,
// modulator loopback, reset with a sample in flight) with hand-derived expectations.
// Latency: n/a. Backpressure: n/a.

module tb_pdm_demod;

  localparam int NBITS      = 11;
  localparam int ORDER      = 3;
  localparam int LOG2_DECIM = 6;
  localparam int R          = 64;
  localparam int MAXV       = 2047;
  localparam int SHIFT      = 7;    // W-1-NBITS = 19-1-11
  localparam int HIST       = 4096;
`ifdef PDM_DEMOD_SYNC_EN
  localparam int LAT = ORDER + 1 + 2;
`else
  localparam int LAT = ORDER + 1;
`endif

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             pdm_in = 1'b0;
  logic             pdm_en = 1'b0;
  logic [NBITS-1:0] data_out;
  logic             data_valid;
  logic             sat;

  pdm_demod #(
    .NBITS      (NBITS),
    .ORDER      (ORDER),
    .LOG2_DECIM (LOG2_DECIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pdm_in     (pdm_in),
    .pdm_en     (pdm_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bench-side state: enabled-bit history, frame end cycles, expectations.
  int nbits_fed = 0;
  int e0_q[$];
  int xh[HIST];
  int b1[HIST];
  int b2[HIST];
  int b3[HIST];
  int nval      = 0;
  int prev_vcyc = 0;
  int mode      = 0;  // 0 none, 1 constant expectation, 2 reference filter
  int exp_dat   = 0;
  int exp_sat   = 0;
  int exp_per   = 0;
  int last_dat  = 0;
  int mod_d     = 0;
  int acc       = 0;

  // Reference filter: three cascaded 64-tap running sums over the enabled bits.
  task automatic push_bit(input int b);
    int k;
    k = nbits_fed;
    if (k < HIST) begin
      xh[k] = b;
      b1[k] = (k > 0 ? b1[k-1] : 0) + b     - (k >= R ? xh[k-R] : 0);
      b2[k] = (k > 0 ? b2[k-1] : 0) + b1[k] - (k >= R ? b1[k-R] : 0);
      b3[k] = (k > 0 ? b3[k-1] : 0) + b2[k] - (k >= R ? b2[k-R] : 0);
    end
    nbits_fed++;
  endtask

  // One clock: inputs held from just after an edge until just after the next one.
  task automatic step(input logic en, input logic b);
    pdm_en = en;
    pdm_in = b;
    @(posedge clk);
    #1;
    if (en) begin
      push_bit(int'(b));
      if (nbits_fed % R == 0) e0_q.push_back(cyc);
    end
  endtask

  // pat: 0 all zeros, 1 all ones, 2 alternating 1,0, 3 first-order modulator of mod_d
  task automatic run_frames(input int nfr, input int gap, input int pat);
    for (int i = 0; i < nfr * R; i++) begin
      logic b;
      case (pat)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (i % 2 == 0);
        default: begin
          acc = acc + mod_d;
          b   = (acc >= 2048);
          acc = acc % 2048;
        end
      endcase
      for (int g = 1; g < gap; g++) step(1'b0, 1'b0);
      step(1'b1, b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_data_out", int'(data_out), 0);
    chk_eq("rst_data_valid", int'(data_valid), 0);
    chk_eq("rst_sat", int'(sat), 0);
    nbits_fed = 0;
    e0_q.delete();
    nval    = 0;
    mode    = 0;
    exp_per = 0;
    acc     = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: n-th valid since reset belongs to frame n+ORDER.
  always @(negedge clk) begin : mon
    int m, idx, y, s;
    if (rst_n && data_valid) begin
      m = nval + ORDER;
      if (m < e0_q.size()) chk_eq("latency", cyc - e0_q[m], LAT);
      else chk_eq("frames_before_valid", e0_q.size(), m + 1);
      if (nval > 0 && exp_per > 0) chk_eq("period", cyc - prev_vcyc, exp_per);
      if (mode == 1) begin
        chk_eq("data_out", int'(data_out), exp_dat);
        chk_eq("sat", int'(sat), exp_sat);
      end else if (mode == 2) begin
        idx = R * m + R - ORDER;
        if (idx < nbits_fed && idx < HIST) begin
          y = b3[idx];
          s = y >>> SHIFT;
          chk_eq("lb_data_out", int'(data_out), (s > MAXV) ? MAXV : s);
          chk_eq("lb_sat", int'(sat), (s > MAXV) ? 1 : 0);
        end else begin
          chk_eq("lb_history", nbits_fed, idx + 1);
        end
      end
      last_dat  = int'(data_out);
      prev_vcyc = cyc;
      nval++;
    end
  end

  initial begin
    @(posedge clk);
    #1;

    // Constant ones: full-scale clamp.
    do_reset();
    mode = 1; exp_dat = MAXV; exp_sat = 1; exp_per = R;
    run_frames(8, 1, 1);
    drain();
    chk_eq("n_valid_ones", nval, 5);

    // Constant zeros.
    do_reset();
    mode = 1; exp_dat = 0; exp_sat = 0; exp_per = R;
    run_frames(8, 1, 0);
    drain();
    chk_eq("n_valid_zeros", nval, 5);

    // Alternating pattern, enable tied high: half scale, 64-clock period.
    do_reset();
    mode = 1; exp_dat = 1024; exp_sat = 0; exp_per = R;
    run_frames(8, 1, 2);
    drain();
    chk_eq("n_valid_alt", nval, 5);

    // Alternating pattern, enable every 3rd clock: same value, 192-clock period.
    do_reset();
    mode = 1; exp_dat = 1024; exp_sat = 0; exp_per = 3 * R;
    run_frames(6, 3, 2);
    drain();
    chk_eq("n_valid_sparse", nval, 3);

    // Loopback through a first-order modulator: 512 then 1500.
    do_reset();
    mode = 2; exp_per = R; mod_d = 512;
    run_frames(12, 1, 3);
    chk_eq("lb_512_settled", last_dat, 512);
    mod_d = 1500;
    run_frames(12, 1, 3);
    drain();
    chk_eq("n_valid_loopback", nval, 21);

    // Reset one clock after a frame completes: pending sample must vanish.
    do_reset();
    mode = 1; exp_dat = 1024; exp_sat = 0; exp_per = R;
    run_frames(6, 1, 2);
    step(1'b1, 1'b1);
    chk_eq("n_valid_before_rst", nval, 2);
    do_reset();
    mode = 1; exp_dat = 1024; exp_sat = 0; exp_per = R;
    run_frames(6, 1, 2);
    drain();
    chk_eq("n_valid_after_rst", nval, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
